// File: rtl/fpu_txn_pkg.sv
// Shared types and constants for the FPU transaction wrapper.
// Flag byte order: [7] inf .. [0] div_by_zero.
package fpu_txn_pkg;

  localparam int unsigned FLAG_W           = 8;
  localparam int unsigned FLAG_INF         = 7;
  localparam int unsigned FLAG_SNAN        = 6;
  localparam int unsigned FLAG_QNAN        = 5;
  localparam int unsigned FLAG_INE         = 4;
  localparam int unsigned FLAG_OVERFLOW    = 3;
  localparam int unsigned FLAG_UNDERFLOW   = 2;
  localparam int unsigned FLAG_ZERO        = 1;
  localparam int unsigned FLAG_DIV_BY_ZERO = 0;

  localparam logic [FLAG_W-1:0] EXC_MASK = 8'h1C | 8'h01 | 8'h40;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_TAG_W = 4;

  typedef struct packed {
    logic inf;
    logic snan;
    logic qnan;
    logic ine;
    logic overflow;
    logic underflow;
    logic zero;
    logic div_by_zero;
  } fpu_flags_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    fpu_flags_t           flags;
    logic [DEF_TAG_W-1:0] tag;
  } fpu_res_t;

  function automatic logic is_exception(input fpu_flags_t f);
    return |(8'(f) & EXC_MASK);
  endfunction

endpackage

// File: rtl/fpu_txn_if.sv
// Request/result handshake plus core-side pin bundle of fpu_txn_pipe.
interface fpu_txn_if
  import fpu_txn_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_rmode;
  logic [2:0]       in_fpu_op;
  logic [WIDTH-1:0] in_opa;
  logic [WIDTH-1:0] in_opb;
  logic [TAG_W-1:0] in_tag;

  logic [1:0]       fpu_rmode;
  logic [2:0]       fpu_op;
  logic [WIDTH-1:0] fpu_opa;
  logic [WIDTH-1:0] fpu_opb;
  logic [WIDTH-1:0] fpu_out;
  fpu_flags_t       fpu_flags;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  fpu_flags_t       out_flags;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_rmode, in_fpu_op, in_opa, in_opb, in_tag,
    output in_ready,
    output fpu_rmode, fpu_op, fpu_opa, fpu_opb,
    input  fpu_out, fpu_flags,
    output out_valid, out_data, out_flags, out_tag,
    input  out_ready
  );

  modport master (
    output in_valid, in_rmode, in_fpu_op, in_opa, in_opb, in_tag,
    input  in_ready,
    input  fpu_rmode, fpu_op, fpu_opa, fpu_opb,
    output fpu_out, fpu_flags,
    input  out_valid, out_data, out_flags, out_tag,
    output out_ready
  );

endinterface

// File: rtl/fpu_txn_fifo.sv
// Synchronous FIFO with a registered head entry; any DEPTH >= 2 (pointers wrap modulo DEPTH).
module fpu_txn_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter type         T     = logic [7:0]
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  T                             wdata,
  input  logic                         pop,
  output T                             rdata,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nx;
  logic [PTR_W-1:0] rd_ptr_nx;
  logic [CNT_W-1:0] count_nx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_nx = push ? ptr_inc(wr_ptr) : wr_ptr;
    rd_ptr_nx = pop  ? ptr_inc(rd_ptr) : rd_ptr;
    count_nx  = count;
    case ({push, pop})
      2'b10:   count_nx = count + CNT_W'(1);
      2'b01:   count_nx = count - CNT_W'(1);
      default: count_nx = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Head register: next head bypasses the write when it lands in an empty slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      valid  <= 1'b0;
      rdata  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nx;
      rd_ptr <= rd_ptr_nx;
      count  <= count_nx;
      full   <= (count_nx == CNT_W'(DEPTH));
      empty  <= (count_nx == '0);
      valid  <= (count_nx != '0);
      if (count_nx != '0)
        rdata <= (push && (wr_ptr == rd_ptr_nx)) ? wdata : mem[rd_ptr_nx];
    end
  end

endmodule

// File: rtl/fpu_txn_pipe.sv
// Valid/ready + tag-tracking wrapper around a fixed-latency, non-stallable FPU core.
// Optional FPU_TXN_PIPE_EXC_COUNT_EN adds a saturating 16-bit exception counter port.
module fpu_txn_pipe
  import fpu_txn_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TAG_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  fpu_txn_if.slave    bus
`ifdef FPU_TXN_PIPE_EXC_COUNT_EN
  ,
  output logic [15:0] exc_count
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    fpu_flags_t       flags;
    logic [TAG_W-1:0] tag;
  } res_t;

  logic             accept;
  logic             push;
  logic             pop;
  logic             in_ready_q;
  logic [CNT_W-1:0] used;
  logic [CNT_W-1:0] used_next;
  logic [LATENCY:0] line_valid;
  logic [TAG_W-1:0] line_tag [0:LATENCY];

  res_t             fifo_wdata;
  res_t             fifo_rdata;
  logic             fifo_valid;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  assign accept = bus.in_valid && in_ready_q;
  assign push   = line_valid[LATENCY];
  assign pop    = fifo_valid && bus.out_ready;

  assign bus.in_ready = in_ready_q;

  // Core operand registers hold between accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.fpu_rmode <= '0;
      bus.fpu_op    <= '0;
      bus.fpu_opa   <= '0;
      bus.fpu_opb   <= '0;
    end else if (accept) begin
      bus.fpu_rmode <= bus.in_rmode;
      bus.fpu_op    <= bus.in_fpu_op;
      bus.fpu_opa   <= bus.in_opa;
      bus.fpu_opb   <= bus.in_opb;
    end
  end

  // Valid/tag line mirrors the core pipeline, shifting every cycle.
  always_ff @(posedge clk) begin
    if (rst) line_valid <= '0;
    else     line_valid <= {line_valid[LATENCY-1:0], accept};
  end

  always_ff @(posedge clk) begin
    line_tag[0] <= bus.in_tag;
    for (int unsigned i = 1; i <= LATENCY; i++) line_tag[i] <= line_tag[i-1];
  end

  // Credits in use = in-flight + buffered; a slot is reserved at accept, freed at pop.
  always_comb begin
    used_next = used;
    if (accept) used_next = used_next + CNT_W'(1);
    if (pop)    used_next = used_next - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      used       <= '0;
      in_ready_q <= 1'b1;
    end else begin
      used       <= used_next;
      in_ready_q <= (used_next < CNT_W'(DEPTH));
    end
  end

  assign fifo_wdata = '{data: bus.fpu_out, flags: bus.fpu_flags, tag: line_tag[LATENCY]};

  fpu_txn_fifo #(
    .DEPTH (DEPTH),
    .T     (res_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .valid (fifo_valid),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_valid = fifo_valid;
  assign bus.out_data  = fifo_rdata.data;
  assign bus.out_flags = fifo_rdata.flags;
  assign bus.out_tag   = fifo_rdata.tag;

`ifdef FPU_TXN_PIPE_EXC_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      exc_count <= '0;
    else if (push && is_exception(bus.fpu_flags) && (exc_count != 16'hFFFF))
      exc_count <= exc_count + 16'd1;
  end
`endif

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));
  a_credit_sum:   assert property (@(posedge clk) disable iff (rst)
                    32'(used) == 32'($countones(line_valid)) + 32'(fifo_count));
  a_valid_empty:  assert property (@(posedge clk) disable iff (rst) fifo_valid != fifo_empty);

endmodule
